// File: rtl/sme_param.sv
// sme_param: string-match engine with '^', '$', '.' and a single '*'; one token compare per scan cycle.
module sme_param #(
  parameter int CHAR_W    = 8,
  parameter int STR_MAX   = 32,
  parameter int PAT_MAX   = 8,
  parameter int CASE_FOLD = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHAR_W-1:0]          chardata,
  input  logic                       isstring,
  input  logic                       ispattern,
  output logic                       busy,
  output logic                       valid,
  output logic                       match,
  output logic [$clog2(STR_MAX)-1:0] match_index
);
  localparam int IW = $clog2(STR_MAX);
  localparam int LW = IW + 1;
  localparam int KW = $clog2(PAT_MAX + 1);
  localparam int PW = $clog2(PAT_MAX);
  localparam logic [CHAR_W-1:0] SP    = CHAR_W'(8'h20);
  localparam logic [CHAR_W-1:0] CARET = CHAR_W'(8'h5E);
  localparam logic [CHAR_W-1:0] DOL   = CHAR_W'(8'h24);
  localparam logic [CHAR_W-1:0] DOT   = CHAR_W'(8'h2E);
  localparam logic [CHAR_W-1:0] STAR  = CHAR_W'(8'h2A);

  typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SCAN, DONE} state_t;
  state_t state, state_n;

  logic [CHAR_W-1:0] str [STR_MAX];
  logic [CHAR_W-1:0] pat [PAT_MAX];
  logic [LW-1:0] len, s, p, t;
  logic [KW-1:0] plen, k, k2;
  logic [1:0] stars;
  logic phase;

  function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
    return (CASE_FOLD != 0 && c >= CHAR_W'(65) && c <= CHAR_W'(90)) ? c + CHAR_W'(32) : c;
  endfunction

  logic [CHAR_W-1:0] tok, pc;
  logic [IW-1:0] pm1;
  logic in_rng, is_car, is_dol, is_dot, is_star, tok_ok, at_end, fail, scan_done, found, star_in;

  assign tok     = pat[k[PW-1:0]];
  assign pc      = str[p[IW-1:0]];
  assign pm1     = p[IW-1:0] - IW'(1);
  assign in_rng  = p < len;
  assign is_car  = tok == CARET;
  assign is_dol  = tok == DOL;
  assign is_dot  = tok == DOT;
  assign is_star = tok == STAR;
  // Anchors look at neighbours without consuming; anything at or past len is the end sentinel.
  assign tok_ok  = is_car ? (p == '0 || str[pm1] == SP) :
                   is_dol ? (!in_rng || pc == SP) :
                   is_dot ? in_rng : (in_rng && fold(pc) == fold(tok));
  assign at_end    = k == plen;
  assign fail      = !is_star && !tok_ok;
  assign found     = !stars[1] && at_end;
  assign scan_done = stars[1] || at_end || (fail && (phase ? t == len : s == len));
  assign star_in   = chardata == STAR;
  assign busy      = state == SCAN || state == DONE;
  assign valid     = state == DONE;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     state_n = ispattern ? LOAD_PAT : isstring ? LOAD_STR : IDLE;
      LOAD_STR: state_n = ispattern ? LOAD_PAT : LOAD_STR;
      LOAD_PAT: state_n = ispattern ? LOAD_PAT : SCAN;
      SCAN:     state_n = scan_done ? DONE : SCAN;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      len         <= '0;
      plen        <= '0;
      stars       <= '0;
      s           <= '0;
      p           <= '0;
      t           <= '0;
      k           <= '0;
      k2          <= '0;
      phase       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
      for (int i = 0; i < STR_MAX; i++) str[i] <= SP;
      for (int i = 0; i < PAT_MAX; i++) pat[i] <= SP;
    end else begin
      state <= state_n;
      if ((state == IDLE || state == LOAD_STR) && ispattern) begin
        pat[0] <= chardata;
        plen   <= KW'(1);
        stars  <= {1'b0, star_in};
      end else if (state == IDLE && isstring) begin
        str[0] <= chardata;
        len    <= LW'(1);
      end else if (state == LOAD_STR && isstring && len < LW'(STR_MAX)) begin
        str[len[IW-1:0]] <= chardata;
        len              <= len + LW'(1);
      end else if (state == LOAD_PAT) begin
        if (ispattern && plen < KW'(PAT_MAX)) begin
          pat[plen[PW-1:0]] <= chardata;
          plen              <= plen + KW'(1);
          stars             <= stars + {1'b0, star_in && !stars[1]};
        end else if (!ispattern) begin
          s     <= '0;
          p     <= '0;
          k     <= '0;
          phase <= 1'b0;
        end
      end else if (state == SCAN) begin
        if (scan_done) begin
          match       <= found;
          match_index <= found ? s[IW-1:0] : '0;
        end else if (is_star) begin
          phase <= 1'b1;
          k     <= k + KW'(1);
          k2    <= k + KW'(1);
          t     <= p;
        end else if (tok_ok) begin
          k <= k + KW'(1);
          p <= p + LW'(!(is_car || is_dol));
        end else if (phase) begin
          t <= t + LW'(1);
          p <= t + LW'(1);
          k <= k2;
        end else begin
          s <= s + LW'(1);
          p <= s + LW'(1);
          k <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sme_param.sv
// tb_sme_param: vector table, random jobs against a string-level reference model, and abort/busy sequences.
module tb_sme_param;
  localparam int SM = 32, PM = 8, IW = 5, LIM = (SM + 1) * (PM + 1) + 3;
  logic clk = 1'b0, reset = 1'b1, isstring = 1'b0, ispattern = 1'b0;
  logic [7:0] chardata = '0;
  logic busy0, valid0, match0, busy1, valid1, match1;
  logic [IW-1:0] idx0, idx1;
  int tests = 0, fails = 0;
  string cur = "";

  always #5 clk = ~clk;

  sme_param #(.CHAR_W(8), .STR_MAX(SM), .PAT_MAX(PM), .CASE_FOLD(0)) dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .busy(busy0), .valid(valid0), .match(match0), .match_index(idx0));
  sme_param #(.CHAR_W(8), .STR_MAX(SM), .PAT_MAX(PM), .CASE_FOLD(1)) dut_f (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .busy(busy1), .valid(valid1), .match(match1), .match_index(idx1));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic byte fl(input byte c, input bit cf);
    return (cf && c >= "A" && c <= "Z") ? byte'(c + 32) : c;
  endfunction

  // End position after matching piece pc at pos, or -1.
  function automatic int seg_at(input string s, input string pc, input int pos, input bit cf);
    int q = pos;
    for (int i = 0; i < pc.len(); i++) begin
      byte c = pc[i];
      if (c == "^") begin
        if (!(q == 0 || s[q-1] == " ")) return -1;
      end else if (c == "$") begin
        if (!(q == s.len() || s[q] == " ")) return -1;
      end else begin
        if (q >= s.len()) return -1;
        if (c != "." && fl(c, cf) != fl(s[q], cf)) return -1;
        q++;
      end
    end
    return q;
  endfunction

  function automatic void model(input string s, input string p, input bit cf, output bit m, output int idx);
    int stars = 0, sp = -1, e;
    string p1, p2;
    m = 0;
    idx = 0;
    for (int i = 0; i < p.len(); i++) if (p[i] == "*") begin stars++; if (sp < 0) sp = i; end
    if (stars > 1) return;
    p1 = (sp < 0) ? p : p.substr(0, sp - 1);
    p2 = (sp < 0) ? "" : p.substr(sp + 1, p.len() - 1);
    for (int st = 0; st <= s.len(); st++) begin
      e = seg_at(s, p1, st, cf);
      if (e < 0) continue;
      for (int t = e; t <= s.len(); t++)
        if (sp < 0 || seg_at(s, p2, t, cf) >= 0) begin m = 1; idx = st % SM; return; end
    end
  endfunction

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      chardata = s[i];
      isstring = 1'b1;
    end
    @(negedge clk);
    isstring = 1'b0;
    cur = (s.len() > SM) ? s.substr(0, SM - 1) : s;
  endtask

  task automatic load_pat(input string p);
    for (int i = 0; i < p.len(); i++) begin
      @(negedge clk);
      chardata = p[i];
      ispattern = 1'b1;
    end
    @(negedge clk);
    ispattern = 1'b0;
  endtask

  task automatic finish_job(input string nm, input bit em, input int ei, input bit emf, input int eif);
    bit ok0 = 0, ok1 = 0;
    logic m0 = 0, m1 = 0;
    logic [IW-1:0] i0 = '0, i1 = '0;
    for (int c = 0; c < LIM && !(ok0 && ok1); c++) begin
      @(negedge clk);
      if (valid0 && !ok0) begin ok0 = 1; m0 = match0; i0 = idx0; end
      if (valid1 && !ok1) begin ok1 = 1; m1 = match1; i1 = idx1; end
    end
    check({nm, "_valid"}, {31'b0, ok0}, 1);
    check({nm, "_match"}, {31'b0, m0}, {31'b0, em});
    check({nm, "_idx"}, {27'b0, i0}, ei);
    check({nm, "_valid_fold"}, {31'b0, ok1}, 1);
    check({nm, "_match_fold"}, {31'b0, m1}, {31'b0, emf});
    check({nm, "_idx_fold"}, {27'b0, i1}, eif);
  endtask

  task automatic job(input string nm, input string p, input bit em, input int ei, input bit emf, input int eif);
    load_pat(p);
    finish_job(nm, em, ei, emf, eif);
  endtask

  typedef struct {string s; string p; bit m; int idx; bit mf; int idxf;} vec_t;
  vec_t tbl[14];

  initial begin
    string s32, ts, tp, alpha_s, alpha_p;
    bit m, mf;
    int ix, ixf, nv;
    s32 = "xyzxyzxyzxyzxyzxyzxyzxyzxyzxyzpq";
    tbl[0]  = '{"abc abd", "abd", 1, 4, 1, 4};
    tbl[1]  = '{"", "^ab", 1, 0, 1, 0};
    tbl[2]  = '{"", "c$", 1, 2, 1, 2};
    tbl[3]  = '{"", "x", 0, 0, 0, 0};
    tbl[4]  = '{"hello world", "l*or", 1, 2, 1, 2};
    tbl[5]  = '{"", "o*z", 0, 0, 0, 0};
    tbl[6]  = '{"", "*d$", 1, 0, 1, 0};
    tbl[7]  = '{"", "^wor", 1, 6, 1, 6};
    tbl[8]  = '{"", "o w", 1, 4, 1, 4};
    tbl[9]  = '{"", "o*w*d", 0, 0, 0, 0};
    tbl[10] = '{s32, ".q$", 1, 30, 1, 30};
    tbl[11] = '{"", "xyzxyzxyAB", 1, 0, 1, 0};
    tbl[12] = '{"", "q$", 1, 31, 1, 31};
    tbl[13] = '{"ABC", "b.$", 0, 0, 1, 1};

    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, valid0}, 0);
    check("rst_match", {31'b0, match0}, 0);
    check("rst_idx", {27'b0, idx0}, 0);
    check("rst_busy", {31'b0, busy0}, 0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      ts = tbl[i].s;
      if (ts.len() > 0) load_str(ts);
      job($sformatf("vec%0d", i), tbl[i].p, tbl[i].m, tbl[i].idx, tbl[i].mf, tbl[i].idxf);
    end

    alpha_s = "abAB ";
    alpha_p = "ab.^$* A";
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        ts = "";
        for (int j = $urandom_range(1, SM + 4); j > 0; j--) ts = $sformatf("%s%c", ts, alpha_s[$urandom_range(0, 4)]);
        load_str(ts);
      end
      tp = "";
      for (int j = $urandom_range(1, PM + 2); j > 0; j--) tp = $sformatf("%s%c", tp, alpha_p[$urandom_range(0, 7)]);
      model(cur, (tp.len() > PM) ? tp.substr(0, PM - 1) : tp, 0, m, ix);
      model(cur, (tp.len() > PM) ? tp.substr(0, PM - 1) : tp, 1, mf, ixf);
      job($sformatf("rnd%0d", n), tp, m, ix, mf, ixf);
    end

    load_str("aaaaaaaaaaaaaaaaaaaa");
    load_pat("aaaaaaab");
    isstring = 1'b1;
    chardata = "b";
    repeat (6) @(negedge clk);
    check("busy_scan", {31'b0, busy0}, 1);
    isstring = 1'b0;
    finish_job("hold", 0, 0, 0, 0);
    job("hold_b", "b", 0, 0, 0, 0);
    job("hold_len", "a$", 1, 19, 1, 19);

    load_pat("aaaaaaab");
    repeat (10) @(negedge clk);
    check("abort_busy_pre", {31'b0, busy0}, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_valid", {31'b0, valid0}, 0);
    check("abort_match", {31'b0, match0}, 0);
    check("abort_idx", {27'b0, idx0}, 0);
    check("abort_busy", {31'b0, busy0}, 0);
    @(negedge clk);
    reset = 1'b0;
    cur = "";
    nv = 0;
    repeat (LIM) begin
      @(negedge clk);
      if (valid0 || valid1) nv++;
    end
    check("abort_no_valid", nv, 0);
    job("post_rst_dollar", "$", 1, 0, 1, 0);
    job("post_rst_a", "a", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
